// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction-fetch stage: PC, imem req/ack handshake, IF/ID
//            register, jump/branch redirect with squash, one-word skid.
//            Optional macro FETCH_PERF_EN enables the performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch,
    input  logic        zero,
    input  logic [31:0] branch_target,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [5:0]  if_opcode,
    output logic [5:0]  if_funct,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] perf_fetch_cnt,
    output logic [15:0] perf_squash_cnt
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_SQUASH = 2'd2;
    localparam logic [1:0] S_SKID   = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic        r_imem_req;
    logic [31:0] r_pc;
    logic [31:0] r_pend;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_if_pc;

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_accept;

    logic        w_load_ifid_mem;
    logic        w_load_ifid_skid;
    logic        w_load_skid;
    logic        w_pc_inc;
    logic        w_pc_target;
    logic        w_pc_pend;
    logic        w_pend_load;

    assign w_redirect = r_valid && (jump || (branch && zero));
    assign w_target   = jump ? jump_target : branch_target;
    assign w_accept   = !r_valid || !stall || w_redirect;

    // State register; imem_req is registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_imem_req <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_imem_req <= (w_next_state == S_REQ) || (w_next_state == S_SQUASH);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   w_next_state = S_REQ;
            S_REQ: begin
                if (imem_ack && !w_redirect && !w_accept)
                    w_next_state = S_SKID;
                else if (!imem_ack && w_redirect)
                    w_next_state = S_SQUASH;
            end
            S_SQUASH: if (imem_ack) w_next_state = S_REQ;
            S_SKID:   if (w_redirect || !stall) w_next_state = S_REQ;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_load_ifid_mem  = 1'b0;
        w_load_ifid_skid = 1'b0;
        w_load_skid      = 1'b0;
        w_pc_inc         = 1'b0;
        w_pc_target      = 1'b0;
        w_pc_pend        = 1'b0;
        w_pend_load      = 1'b0;
        case (r_state)
            S_REQ: begin
                if (imem_ack) begin
                    if (w_redirect) begin
                        w_pc_target = 1'b1;
                    end else if (w_accept) begin
                        w_load_ifid_mem = 1'b1;
                        w_pc_inc        = 1'b1;
                    end else begin
                        w_load_skid = 1'b1;
                        w_pc_inc    = 1'b1;
                    end
                end else if (w_redirect) begin
                    w_pend_load = 1'b1;
                end
            end
            S_SQUASH: begin
                if (w_redirect)
                    w_pend_load = 1'b1;
                // The newest redirect wins if it coincides with the ack
                if (imem_ack) begin
                    if (w_redirect)
                        w_pc_target = 1'b1;
                    else
                        w_pc_pend = 1'b1;
                end
            end
            S_SKID: begin
                if (w_redirect)
                    w_pc_target = 1'b1;
                else if (!stall)
                    w_load_ifid_skid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_pend       <= 32'h0;
            r_skid_instr <= 32'h0;
            r_skid_pc    <= 32'h0;
            r_valid      <= 1'b0;
            r_instr      <= 32'h0;
            r_if_pc      <= 32'h0;
        end else begin
            if (w_pc_target)
                r_pc <= w_target;
            else if (w_pc_pend)
                r_pc <= r_pend;
            else if (w_pc_inc)
                r_pc <= r_pc + 32'd4;

            if (w_pend_load)
                r_pend <= w_target;

            if (w_load_skid) begin
                r_skid_instr <= imem_rdata;
                r_skid_pc    <= r_pc;
            end

            if (w_load_ifid_mem) begin
                r_instr <= imem_rdata;
                r_if_pc <= r_pc;
            end else if (w_load_ifid_skid) begin
                r_instr <= r_skid_instr;
                r_if_pc <= r_skid_pc;
            end

            // Entry survives only if it is neither consumed nor redirected
            if (w_load_ifid_mem || w_load_ifid_skid)
                r_valid <= 1'b1;
            else
                r_valid <= r_valid && stall && !w_redirect;
        end
    end

`ifdef FETCH_PERF_EN
    logic        w_discard;
    logic [31:0] r_fetch_cnt;
    logic [15:0] r_squash_cnt;

    assign w_discard = ((r_state == S_REQ)    && imem_ack && w_redirect) ||
                       ((r_state == S_SQUASH) && imem_ack) ||
                       ((r_state == S_SKID)   && w_redirect);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt  <= 32'h0;
            r_squash_cnt <= 16'h0;
        end else begin
            if (w_load_ifid_mem || w_load_skid)
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (w_discard)
                r_squash_cnt <= r_squash_cnt + 16'd1;
        end
    end

    assign perf_fetch_cnt  = r_fetch_cnt;
    assign perf_squash_cnt = r_squash_cnt;
`else
    assign perf_fetch_cnt  = 32'h0;
    assign perf_squash_cnt = 16'h0;
`endif

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign if_valid    = r_valid;
    assign if_instr    = r_instr;
    assign if_opcode   = r_instr[31:26];
    assign if_funct    = r_instr[5:0];
    assign if_pc       = r_if_pc;
    assign if_pc_plus4 = r_if_pc + 32'd4;

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage feeding the main control decoder. Holds the PC, issues word requests to instruction memory over a req/ack handshake, and presents the fetched instruction (plus opcode/funct slices and PC) in a single-entry IF/ID register. Redirects on jump or taken branch by squashing in-flight and buffered instructions. Absorbs downstream stalls with a one-word skid register.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request; registered.
- `imem_addr`  out  32  word address (= PC); stable while `imem_req`=1.
- `imem_ack`  in  1  transfer completes in any cycle with `imem_req && imem_ack`.
- `imem_rdata`  in  32  instruction word; valid in the ack cycle.
- `stall`  in  1  downstream cannot consume the IF/ID entry this cycle.
- `jump`  in  1  jump decoded for the current IF/ID instruction.
- `jump_target`  in  32  jump destination.
- `branch`, `zero`  in  1 each  branch decoded / ALU zero; taken = `branch && zero`.
- `branch_target`  in  32  branch destination.
- `if_valid`  out  1  IF/ID entry valid.
- `if_instr`  out  32  instruction.
- `if_opcode`  out  6  `if_instr[31:26]`, combinational.
- `if_funct`  out  6  `if_instr[5:0]`, combinational.
- `if_pc`  out  32  address of `if_instr`.
- `if_pc_plus4`  out  32  `if_pc + 4`, combinational.
- `perf_fetch_cnt`  out  32  completed fetches accepted (see Configuration).
- `perf_squash_cnt`  out  16  fetches discarded by redirect.

## Operation
- `redirect` = `if_valid && (jump || (branch && zero))`; `target` = `jump_target` if `jump`, else `branch_target` (jump wins). Redirect is ignored when `if_valid`=0.
- `accept` = `!if_valid || !stall || redirect`.
- States: IDLE, REQ, SQUASH, SKID. `imem_req` = 1 in REQ and SQUASH, else 0.
- IDLE: entered only from reset; next cycle -> REQ.
- REQ, no ack: `redirect` -> `pend` <= `target`, -> SQUASH; else stay.
- REQ, ack, `redirect`: drop `imem_rdata`, `pc` <= `target`, `if_valid` <= 0, stay REQ.
- REQ, ack, no redirect, `accept`: IF/ID <= {`imem_rdata`, `pc`}, `if_valid` <= 1, `pc` <= `pc`+4, stay REQ.
- REQ, ack, no redirect, !`accept`: skid <= {`imem_rdata`, `pc`}, `pc` <= `pc`+4, -> SKID.
- SQUASH: further redirects overwrite `pend`; on ack drop data, `pc` <= `pend`, -> REQ.
- SKID: `redirect` -> drop skid, `if_valid` <= 0, `pc` <= `target`, -> REQ. `!stall` -> IF/ID <= skid, -> REQ. Else hold.
- Consumption without refill (`if_valid && !stall`, no new word loaded) clears `if_valid`.
- Any `redirect` clears `if_valid` next cycle regardless of `stall`.
- PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0. Targets used as given, no alignment check.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_instr`=0, `if_pc`=0, counters 0, state IDLE.
- `imem_req` rises in the second cycle after `rst` falls.
- Ack in cycle N -> `if_valid`/`if_instr` updated at cycle N+1.
- With `imem_ack` tied 1 and no stall: one instruction per cycle, consecutive PCs.
- Taken redirect in cycle N with ack -> `imem_addr` = `target` at cycle N+1. Redirect without ack -> `target` issued the cycle after the outstanding ack.
- `rst` asserted mid-transaction: outstanding request abandoned, all state to reset values next edge.

## Configuration
- `FETCH_PERF_EN`: when defined, `perf_fetch_cnt` increments on each word loaded into IF/ID or skid; `perf_squash_cnt` increments on each discarded ack (REQ+redirect, SQUASH) and each dropped skid word; both wrap. When undefined, both outputs constant 0 and no counter logic is synthesized.

## Test plan
- Reset, `imem_ack`=1, rdata = addr: `imem_addr` 0,4,8,…; `if_instr` lags by one cycle; `if_valid` stays 1.
- `imem_ack` every third cycle: `imem_addr` held constant while waiting; `if_pc` advances 0,4,8 with bubbles.
- `stall`=1 for 3 cycles during back-to-back fetch: one word goes to skid, `imem_req`=0 in SKID, `if_instr` held; on release skid word appears next cycle, no loss or duplication.
- `jump`=1, `jump_target`=32'h100 while request to 0x8 unacked: ack for 0x8 discarded, next request 0x100, `perf_squash_cnt`=1 with `FETCH_PERF_EN`.
- `jump` and taken `branch` same cycle (targets 0x200/0x300) with stall=1: `if_valid` 0 next cycle, fetch resumes at 0x200.
- `RESET_PC`=32'hFFFF_FFF8, ack=1: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
